tx_scheduler: RTL
=================

TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter DATA_BIT, default 8: width of one payload byte.
REQ-002 Parameter ITEM_COUNT, default 4: number of bytes per batch (depth of downstream transmit buffer).
REQ-003 Parameter LOAD_HOLD, default 4: cycles bufLoad is held high per byte (range 1..255).
REQ-004 Parameter GAP, default 2: cycles of low strobe after each bufLoad or bufTransmit release (range 1..255).
REQ-005 Parameter TIMEOUT, default 2_000_000: maximum cycles to wait for bufDone after raising bufTransmit.
REQ-006 clk  input  1  single system clock; all logic on rising edge.
REQ-007 resetN  input  1  asynchronous, active-low reset.
REQ-008 req  input  2  request lines from requesters 0 and 1; held high until granted.
REQ-009 reqData0  input  DATA_BIT  byte from requester 0, stable while req[0] high.
REQ-010 reqData1  input  DATA_BIT  byte from requester 1, stable while req[1] high.
REQ-011 grant  output  2  one-hot, one-cycle pulse: byte of that requester accepted.
REQ-012 bufData  output  DATA_BIT  byte presented to transmit buffer.
REQ-013 bufLoad  output  1  load strobe to transmit buffer.
REQ-014 bufTransmit  output  1  transmit strobe to transmit buffer.
REQ-015 bufAuto  output  1  auto-transfer select (send whole batch); high whenever bufTransmit high.
REQ-016 bufDone  input  1  batch-complete indication from transmit buffer.
REQ-017 itemCount  output  $clog2(ITEM_COUNT+1)  bytes loaded in current batch.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 timeoutErr  output  1  sticky flag: a batch timed out.

Function
REQ-020 States SHALL be IDLE, ARB, LOAD, LOADGAP, XMIT, RELEASE; exactly one active.
REQ-021 IDLE: if itemCount==ITEM_COUNT -> XMIT; else if req!=0 -> ARB; else stay (batch full has priority over requests).
REQ-022 ARB (one cycle): select requester by round-robin, assert grant for that cycle only, latch its byte into bufData, -> LOAD.
REQ-023 Round-robin: single request wins outright; both requesting -> requester not granted last; pointer reset value selects requester 0 first.
REQ-024 Pointer SHALL update only on an actual grant.
REQ-025 LOAD: bufLoad=1 for exactly LOAD_HOLD cycles, bufData stable, then -> LOADGAP.
REQ-026 itemCount SHALL increment by 1 on the LOAD->LOADGAP transition.
REQ-027 LOADGAP: bufLoad=0 for exactly GAP cycles, then -> IDLE.
REQ-028 XMIT: bufTransmit=1, bufAuto=1; wait counter starts at 0 on entry.
REQ-029 XMIT: bufDone=1 -> RELEASE; else counter reaches TIMEOUT-1 without bufDone -> set timeoutErr, -> RELEASE.
REQ-030 bufDone and timeout in same cycle: treat as done; timeoutErr NOT set.
REQ-031 RELEASE: bufTransmit=0, bufAuto=0 for exactly GAP cycles, itemCount cleared to 0 on entry, then -> IDLE.
REQ-032 No grant SHALL be issued outside ARB; requests arriving in other states wait, none lost or duplicated.
REQ-033 bufDone outside XMIT SHALL be ignored.
REQ-034 bufLoad and bufTransmit SHALL never be high in the same cycle.
REQ-035 itemCount SHALL never exceed ITEM_COUNT.
REQ-036 timeoutErr cleared only by reset.

Reset
REQ-037 resetN low SHALL immediately force IDLE, grant=0, bufLoad=0, bufTransmit=0, bufAuto=0, bufData=0, itemCount=0, busy=0, timeoutErr=0, pointer to requester 0, all counters 0.
REQ-038 Reset mid-LOAD or mid-XMIT SHALL drop strobes asynchronously; partial batch discarded.
REQ-039 After resetN rises, first state evaluation SHALL occur on the next rising clk.

Verification
REQ-040 req=01, reqData0=0x41 from IDLE -> grant=01 one cycle, bufData=0x41, bufLoad high 4 cycles, low 2, itemCount=1.
REQ-041 req=11 held, data0=0xA0, data1=0xB1 -> grants alternate 01,10,01,10; itemCount 1..4; then bufTransmit=bufAuto=1 with no further grant.
REQ-042 Batch full, bufDone pulsed 10 cycles after bufTransmit -> bufTransmit low next cycle, itemCount=0, busy low after 2 GAP cycles.
REQ-043 Batch full, bufDone never asserted, TIMEOUT=100 -> timeoutErr=1 after 100 XMIT cycles, bufTransmit drops, returns IDLE.
REQ-044 resetN pulsed low during LOAD cycle 2 -> bufLoad=0 immediately, itemCount=0, next grant goes to requester 0.

Source files
------------

// File: rtl/tx_scheduler_if.sv
// tx_scheduler_if: bundles the requester-side and transmit-buffer-side signals
// of tx_scheduler.
//   req/reqData0/reqData1 : two requesters, each byte held stable while its req is high
//   grant                 : one-hot acceptance pulse back to the requesters
//   bufData/bufLoad       : byte and load strobe to the transmit buffer
//   bufTransmit/bufAuto   : whole-batch transmit strobes to the transmit buffer
//   bufDone               : batch-complete indication from the transmit buffer
//   itemCount/busy/timeoutErr : status
// master = scheduler side, slave = environment side.
interface tx_scheduler_if #(
  parameter int DATA_BIT   = 8,
  parameter int ITEM_COUNT = 4
);
  logic [1:0]                        req;
  logic [DATA_BIT-1:0]               reqData0;
  logic [DATA_BIT-1:0]               reqData1;
  logic [1:0]                        grant;
  logic [DATA_BIT-1:0]               bufData;
  logic                              bufLoad;
  logic                              bufTransmit;
  logic                              bufAuto;
  logic                              bufDone;
  logic [$clog2(ITEM_COUNT+1)-1:0]   itemCount;
  logic                              busy;
  logic                              timeoutErr;

  modport master (
    input  req, reqData0, reqData1, bufDone,
    output grant, bufData, bufLoad, bufTransmit, bufAuto, itemCount, busy, timeoutErr
  );

  modport slave (
    output req, reqData0, reqData1, bufDone,
    input  grant, bufData, bufLoad, bufTransmit, bufAuto, itemCount, busy, timeoutErr
  );
endinterface

// File: rtl/tx_scheduler.sv
// tx_scheduler: round-robin collects bytes from two requesters into a batch of
// ITEM_COUNT bytes for a downstream transmit buffer, then triggers an
// auto-transfer of the whole batch and waits (bounded by TIMEOUT) for bufDone.
// Ports:
//   clk    : system clock, rising edge
//   resetN : asynchronous active-low reset
//   bus    : tx_scheduler_if.master (requests, grants, buffer strobes, status)
module tx_scheduler #(
  parameter int DATA_BIT   = 8,
  parameter int ITEM_COUNT = 4,
  parameter int LOAD_HOLD  = 4,
  parameter int GAP        = 2,
  parameter int TIMEOUT    = 2_000_000
) (
  input  logic             clk,
  input  logic             resetN,
  tx_scheduler_if.master   bus
);

  localparam int IC_W  = $clog2(ITEM_COUNT + 1);
  // One shared cycle counter serves LOAD, both gaps and the XMIT timeout.
  localparam int CMAX  = (TIMEOUT > 256) ? TIMEOUT : 256;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOAD,
    LOADGAP,
    XMIT,
    RELEASE
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          grant_q;
  logic [DATA_BIT-1:0] data_q;
  logic                load_q;
  logic                xmit_q;
  logic                err_q;
  logic                prio_q;   // 1: requester 1 wins a tie
  logic [IC_W-1:0]     count_q;

  logic [1:0]          grant_d;
  logic [DATA_BIT-1:0] data_d;

  // Arbitration is resolved while leaving IDLE so that grant and bufData are
  // registered and valid for the whole ARB cycle.
  always_comb begin
    grant_d = '0;
    case (bus.req)
      2'b01:   grant_d = 2'b01;
      2'b10:   grant_d = 2'b10;
      2'b11:   grant_d = prio_q ? 2'b10 : 2'b01;
      default: grant_d = '0;
    endcase
    data_d = grant_d[1] ? bus.reqData1 : bus.reqData0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      xmit_q  <= 1'b0;
      err_q   <= 1'b0;
      prio_q  <= 1'b0;
      count_q <= '0;
    end else begin
      grant_q <= '0;
      case (state_q)
        IDLE: begin
          if (count_q == IC_W'(ITEM_COUNT)) begin
            state_q <= XMIT;
            xmit_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (bus.req != 2'b00) begin
            state_q <= ARB;
            grant_q <= grant_d;
            data_q  <= data_d;
            // Granting requester 0 hands the tie to requester 1 and vice versa.
            prio_q  <= grant_d[0];
          end
        end
        ARB: begin
          state_q <= LOAD;
          load_q  <= 1'b1;
          cnt_q   <= '0;
        end
        LOAD: begin
          if (cnt_q == CNT_W'(LOAD_HOLD - 1)) begin
            state_q <= LOADGAP;
            load_q  <= 1'b0;
            cnt_q   <= '0;
            count_q <= count_q + IC_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LOADGAP: begin
          if (cnt_q == CNT_W'(GAP - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        XMIT: begin
          // bufDone has priority: a done arriving on the last allowed cycle
          // is a success, not a timeout.
          if (bus.bufDone || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
            state_q <= RELEASE;
            xmit_q  <= 1'b0;
            count_q <= '0;
            cnt_q   <= '0;
            if (!bus.bufDone) begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == CNT_W'(GAP - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.bufData     = data_q;
  assign bus.bufLoad     = load_q;
  assign bus.bufTransmit = xmit_q;
  assign bus.bufAuto     = xmit_q;
  assign bus.itemCount   = count_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeoutErr  = err_q;

endmodule
